systolic_row_feeder: RTL and testbench

- Sits directly downstream of the 64-bit streaming operand buffer and directly upstream of the systolic array's west edge.
- Accepts 64-bit beats, each holding two 32-bit elements, and assembles them into ROWS-element column vectors.
- Injects each column into the array with diagonal skew: row r is delayed r cycles.
- After the last column of a tile, flushes the skew pipeline and signals done.

---
 rtl/systolic_row_feeder.sv | 194 +++++++++++++++++++
 tb/tb_systolic_row_feeder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_row_feeder.sv
// systolic_row_feeder
//   Takes 64-bit beats from the operand stream buffer. Each beat carries two
//   DATA_W elements. The feeder builds ROWS-element columns from these beats
//   and drives them into the west edge of the systolic array with a diagonal
//   skew, so that row r sees a column r cycles after row 0 does. When the last
//   column of a tile has gone in, it waits for the skew pipeline to empty and
//   then pulses done.
//
//   Optional build macro: FEEDER_STALL_CNT_EN adds the stall_cnt output. That
//   output counts FILL cycles in which upstream has no data. It saturates, and
//   it clears on reset and on an accepted start.
//
//   Ports
//     clk, reset   clock, synchronous active-high reset
//     start, k_len tile start pulse (IDLE only) and column count
//     in_valid/in_ready/in_data   upstream beat handshake; the upper half of
//                                 in_data is the earlier element
//     row_data/row_valid          skewed per-row operands to the array
//     busy         high whenever the feeder is not IDLE
//     done         one-cycle pulse when a tile completes
//     stall_cnt    (FEEDER_STALL_CNT_EN only) count of starved FILL cycles

// One skew lane: a DEPTH-stage delay line for a single row.
module systolic_row_skew #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);
    logic [DEPTH-1:0]             vld_pipe;
    logic [DEPTH-1:0][DATA_W-1:0] dat_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            dat_pipe[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign out_valid = vld_pipe[DEPTH-1];
    assign out_data  = dat_pipe[DEPTH-1];
endmodule

module systolic_row_feeder #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 32,
    parameter int KLEN_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [KLEN_W-1:0]      k_len,
    input  logic                   in_valid,
    input  logic [2*DATA_W-1:0]    in_data,
    output logic                   in_ready,
    output logic [ROWS*DATA_W-1:0] row_data,
    output logic [ROWS-1:0]        row_valid,
    output logic                   busy,
`ifdef FEEDER_STALL_CNT_EN
    output logic [31:0]            stall_cnt,
`endif
    output logic                   done
);
    localparam int BEATS   = ROWS / 2;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int FLUSH_W = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, FILL, ISSUE, FLUSH} state_t;

    state_t                   state, state_nx;
    logic [KLEN_W-1:0]        k_len_q;
    logic [KLEN_W-1:0]        col_cnt;
    logic [KLEN_W-1:0]        col_cnt_inc;
    logic [BEAT_W-1:0]        beat_cnt;
    logic [FLUSH_W-1:0]       flush_cnt;
    logic [ROWS-1:0][DATA_W-1:0] slots;
    logic                     issue;
    logic                     accept;
    logic                     last_beat;
    logic                     last_flush;
    logic                     done_flush;
    logic                     done_zero;

    // col_cnt stays below k_len_q, so the increment cannot wrap even when
    // k_len is all-ones.
    assign col_cnt_inc = col_cnt + 1'b1;
    assign accept      = in_ready && in_valid;
    assign last_beat   = (beat_cnt == BEAT_W'(BEATS - 1));
    assign last_flush  = (flush_cnt == FLUSH_W'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        issue      = 1'b0;
        done_flush = 1'b0;
        case (state)
            IDLE:  if (start && k_len != '0) state_nx = FILL;
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) state_nx = ISSUE;
            end
            ISSUE: begin
                issue    = 1'b1;
                state_nx = (col_cnt_inc == k_len_q) ? FLUSH : FILL;
            end
            FLUSH: begin
                // ROWS cycles: the last column leaves row ROWS-1 in the final one
                if (last_flush) begin
                    done_flush = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = done_flush | done_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            k_len_q   <= '0;
            col_cnt   <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            slots     <= '0;
            done_zero <= 1'b0;
        end else begin
            // zero-length tile: report done on the following cycle
            done_zero <= (state == IDLE) && start && (k_len == '0);
            if (state == IDLE && start && k_len != '0) begin
                k_len_q   <= k_len;
                col_cnt   <= '0;
                beat_cnt  <= '0;
                flush_cnt <= '0;
            end
            if (accept) begin
                for (int b = 0; b < BEATS; b++) begin
                    if (beat_cnt == BEAT_W'(b)) begin
                        slots[2*b]   <= in_data[2*DATA_W-1:DATA_W];
                        slots[2*b+1] <= in_data[DATA_W-1:0];
                    end
                end
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (issue) col_cnt <= col_cnt_inc;
            if (state == FLUSH) flush_cnt <= last_flush ? '0 : flush_cnt + 1'b1;
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (state == IDLE && start)
            stall_cnt <= '0;
        else if (state == FILL && !in_valid && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

    // Lanes get zero data when nothing is issued, so row_data is 0 whenever
    // row_valid is low.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        systolic_row_skew #(
            .DATA_W (DATA_W),
            .DEPTH  (r + 1)
        ) u_skew (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (issue),
            .in_data   (issue ? slots[r] : '0),
            .out_valid (row_valid[r]),
            .out_data  (row_data[r*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_systolic_row_feeder.sv
module tb_systolic_row_feeder;
    localparam int ROWS = 4;
    localparam int DW   = 32;
    localparam int KW   = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [KW-1:0]        k_len;
    logic                 in_valid;
    logic [2*DW-1:0]      in_data;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   row_data;
    logic [ROWS-1:0]      row_valid;
    logic                 busy;
    logic                 done;
`ifdef FEEDER_STALL_CNT_EN
    logic [31:0]          stall_cnt;
`endif

    systolic_row_feeder #(.ROWS(ROWS), .DATA_W(DW), .KLEN_W(KW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .row_data  (row_data),
        .row_valid (row_valid),
        .busy      (busy),
`ifdef FEEDER_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    int row0_cnt = 0;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    exp_t rq[ROWS][$];
    int   dq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected row operands / done pulses as the DUT shows them.
    always @(negedge clk) begin : mon
        exp_t e;
        int   dc;
        if (mon_en) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_valid[r]) begin
                    if (r == 0) row0_cnt++;
                    if (rq[r].size() == 0) begin
                        chk($sformatf("row%0d_unexpected", r), 1, 0);
                    end else begin
                        e = rq[r].pop_front();
                        chk($sformatf("row%0d_data", r), row_data[r*DW +: DW], e.d);
                        chk($sformatf("row%0d_cycle", r), cyc, e.c);
                    end
                end else begin
                    chk($sformatf("row%0d_zero", r), row_data[r*DW +: DW], 0);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    dc = dq.pop_front();
                    chk("done_cycle", cyc, dc);
                end
            end
        end
    end

    // Column issued the cycle after its last beat is accepted (acc), row r
    // shows it at acc + 2 + r.
    task automatic push_col(input logic [ROWS-1:0][DW-1:0] col, input int acc);
        exp_t e;
        for (int r = 0; r < ROWS; r++) begin
            e.d = col[r];
            e.c = acc + 2 + r;
            rq[r].push_back(e);
        end
    endtask

    task automatic start_tile(input int k);
        start = 1'b1;
        k_len = k[KW-1:0];
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, output int acc);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("beat_accept_timeout", 0, 1);
        acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!done) chk({nm, "_done_timeout"}, 0, 1);
        @(negedge clk);
        chk({nm, "_busy_after_done"}, busy, 0);
        chk({nm, "_done_one_cycle"}, done, 0);
        for (int r = 0; r < ROWS; r++) chk({nm, "_rows_drained"}, rq[r].size(), 0);
        @(posedge clk); #1;
    endtask

    logic [63:0]                bt[6];
    logic [ROWS-1:0][DW-1:0]    ct[3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, prev, n;
        logic [63:0] b0, b1;
        reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_row_valid", row_valid, 0);
        chk("rst_row_data", row_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // basic tile, k_len = 1
        start_tile(1);
        send_beat(64'h00000001_00000002, a0);
        send_beat(64'h00000003_00000004, a1);
        chk("basic_beat_gap", a1 - a0, 1);
        push_col({32'd4, 32'd3, 32'd2, 32'd1}, a1);
        dq.push_back(a1 + 5);
        wait_done("basic");
`ifdef FEEDER_STALL_CNT_EN
        chk("basic_stall_cnt", stall_cnt, 0);
`endif

        // back-to-back columns, k_len = 3
        bt = '{64'h11111111_22222222, 64'h33333333_44444444,
               64'h55555555_66666666, 64'h77777777_88888888,
               64'h99999999_AAAAAAAA, 64'hBBBBBBBB_CCCCCCCC};
        ct = '{{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
               {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555},
               {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA, 32'h99999999}};
        start_tile(3);
        prev = 0;
        for (int j = 0; j < 3; j++) begin
            send_beat(bt[2*j], a0);
            send_beat(bt[2*j+1], a1);
            push_col(ct[j], a1);
            if (j > 0) chk("b2b_column_period", a1 - prev, 3);
            prev = a1;
        end
        dq.push_back(a1 + 5);
        wait_done("b2b");

        // upstream stall of 5 cycles between beats
        start_tile(1);
        send_beat(64'hDEADBEEF_CAFEF00D, a0);
        repeat (5) begin @(posedge clk); #1; end
        send_beat(64'h01234567_89ABCDEF, a1);
        chk("stall_beat_gap", a1 - a0, 6);
        push_col({32'h89ABCDEF, 32'h01234567, 32'hCAFEF00D, 32'hDEADBEEF}, a1);
        dq.push_back(a1 + 5);
        wait_done("stall");
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_cnt_value", stall_cnt, 5);
`endif

        // zero-length tile with in_valid coincident
        in_valid = 1'b1;
        in_data  = 64'hFFFF0000_FFFF0000;
        start    = 1'b1;
        k_len    = '0;
        dq.push_back(cyc + 1);
        @(negedge clk);
        chk("zero_in_ready_c0", in_ready, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_in_ready_c1", in_ready, 0);
        chk("zero_done", done, 1);
        @(negedge clk);
        chk("zero_done_one_cycle", done, 0);
        chk("zero_busy", busy, 0);
        chk("zero_in_ready_c2", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_cnt_cleared", stall_cnt, 0);
`endif

        // start pulsed mid-FILL must be ignored
        start_tile(1);
        send_beat(64'h0000AAAA_0000BBBB, a0);
        start = 1'b1;
        k_len = '0;
        send_beat(64'h0000CCCC_0000DDDD, a1);
        start = 1'b0;
        push_col({32'h0000DDDD, 32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA}, a1);
        dq.push_back(a1 + 5);
        wait_done("ignored_start");

        // reset during FLUSH
        start_tile(1);
        send_beat(64'h10000000_20000000, a0);
        send_beat(64'h30000000_40000000, a1);
        push_col({32'h40000000, 32'h30000000, 32'h20000000, 32'h10000000}, a1);
        dq.push_back(a1 + 5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc != a1 + 3 && n < 20);
        chk("flush_row_valid", row_valid, 4'b0010);
        chk("flush_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int r = 0; r < ROWS; r++) rq[r].delete();
        dq.delete();
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_row_valid", row_valid, 0);
        chk("mrst_row_data", row_data, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        @(posedge clk); #1;
        start_tile(1);
        send_beat(64'h00000005_00000006, a0);
        send_beat(64'h00000007_00000008, a1);
        push_col({32'd8, 32'd7, 32'd6, 32'd5}, a1);
        dq.push_back(a1 + 5);
        wait_done("after_reset");

        // counter bound: k_len = 2^KW - 1
        row0_cnt = 0;
        start_tile(15);
        for (int j = 0; j < 15; j++) begin
            b0 = {32'(4*j + 1), 32'(4*j + 2)};
            b1 = {32'(4*j + 3), 32'(4*j + 4)};
            send_beat(b0, a0);
            send_beat(b1, a1);
            push_col({32'(4*j + 4), 32'(4*j + 3), 32'(4*j + 2), 32'(4*j + 1)}, a1);
        end
        dq.push_back(a1 + 5);
        wait_done("k15");
        chk("k15_issue_count", row0_cnt, 15);
        chk("final_done_queue_empty", dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
